// File: rtl/rotfpga_scan_loader.sv
// rotfpga_scan_loader: transmit end of the fabric scan chain.
// Takes config bytes over a valid/ready stream, shifts them LSB-first onto
// scan_sc with scan_se high only while a bit is moving, and packs the bits
// that fall out of scan_out_sc into readback bytes, so the previous
// configuration is read back while the new one is loaded.
module rotfpga_scan_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  output logic       scan_se,
  output logic       scan_sc,
  input  logic       scan_out_sc,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] BYTE_C      = CNT_W'(8);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] bitcnt;       // bits shifted so far in this load
  logic [CNT_W-1:0] remaining;    // bits still to shift in this load
  logic [3:0]       fetch_bits;   // bits to take from the byte being fetched
  logic [3:0]       byte_bits;    // bits to shift from the current byte (1..8)
  logic [2:0]       bit_idx;      // position within the current byte
  logic [7:0]       tx;           // bits of the current byte not yet on scan_sc
  logic [7:0]       rx;           // readback bits collected for the current byte
  logic             accept;
  logic             byte_last;
  logic             chain_last;

  assign accept     = cfg_valid && cfg_ready;
  assign byte_last  = (state == S_SHIFT) && ({1'b0, bit_idx} == byte_bits - 4'd1);
  assign chain_last = (state == S_SHIFT) && (bitcnt == CHAIN_LEN_C - 1'b1);

  // Clip the final byte so a load never shifts past the end of the chain.
  always_comb begin
    remaining  = CHAIN_LEN_C - bitcnt;
    fetch_bits = (remaining >= BYTE_C) ? 4'd8 : remaining[3:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and the stream ready; abort overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_next = state;
    cfg_ready  = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_next = S_SHIFT;
      end
      S_SHIFT:  if (byte_last) state_next = chain_last ? S_FINISH : S_FETCH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    // Masking ready keeps a byte from being swallowed by a load being dropped.
    if (abort) begin
      state_next = S_IDLE;
      cfg_ready  = 1'b0;
    end
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_se <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      scan_se <= (state_next == S_SHIFT);
      busy    <= (state_next == S_FETCH) || (state_next == S_SHIFT);
      done    <= (state_next == S_FINISH);
    end
  end

  // Shift datapath: byte load, serialisation, readback capture and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_sc   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
      bitcnt    <= '0;
      byte_bits <= 4'd0;
      bit_idx   <= 3'd0;
      tx        <= 8'h00;
      rx        <= 8'h00;
    end else begin
      rd_valid <= 1'b0;

      if (state == S_IDLE && start && !abort) bitcnt <= '0;

      // Bit 0 goes straight onto scan_sc; the rest wait in tx.
      if (accept) begin
        scan_sc   <= cfg_data[0];
        tx        <= {1'b0, cfg_data[7:1]};
        rx        <= 8'h00;
        bit_idx   <= 3'd0;
        byte_bits <= fetch_bits;
      end

      // The fabric takes scan_sc on this edge while the chain end is captured.
      if (state == S_SHIFT && !abort) begin
        rx[bit_idx] <= scan_out_sc;
        bit_idx     <= bit_idx + 3'd1;
        bitcnt      <= bitcnt + 1'b1;
        tx          <= {1'b0, tx[7:1]};
        if (byte_last) begin
          // scan_sc keeps the last shifted bit while se is low.
          rd_valid <= 1'b1;
          rd_data  <= rx | (8'(scan_out_sc) << bit_idx);
        end else begin
          scan_sc <= tx[0];
        end
      end
    end
  end

endmodule
